// File: rtl/dsec_stream_ctrl.sv
// dsec_stream_ctrl: DSEC stream controller.
//   Loads a KEY_WORDS-word key and a data stream over one shared input bus. Each data word
//   is XOR-whitened with the next key word in round-robin order and pushed into an output
//   FIFO that is drained under an out_valid/out_rcvd handshake. Protocol violations latch
//   a sticky error; only rst clears it.
// Optional feature macro: DSEC_KEY_RELOAD_EN (key load allowed again while in READY).
// Ports:
//   clk, rst          clock (posedge) and asynchronous active-high reset
//   data_in           key word (key_config=1) or data word (key_config=0)
//   key_config        1 = key-load mode, 0 = data mode
//   in_valid / rdy    input handshake; a word is accepted on a posedge with in_valid & rdy
//   data_out          FIFO head (whitened word)
//   out_valid         FIFO non-empty
//   out_rcvd          consumer takes data_out; pops when out_valid=1
//   error             sticky protocol error
//   key_loaded        full key held, data mode permitted
module dsec_stream_ctrl #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned KEY_WORDS  = 3,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              key_config,
   input  logic              in_valid,
   input  logic              out_rcvd,
   output logic              rdy,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   output logic              error,
   output logic              key_loaded
);

   localparam int unsigned KPW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam logic [KPW-1:0] KeyLast = KPW'(KEY_WORDS - 1);
   localparam logic [AW:0]    FullCnt = (AW + 1)'(FIFO_DEPTH);

`ifdef DSEC_KEY_RELOAD_EN
   localparam bit ReloadEn = 1'b1;
`else
   localparam bit ReloadEn = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StLoad, StReady, StErr} state_e;

   state_e            state_q, state_d;
   logic              live_q;
   logic [DATA_W-1:0] key_q [KEY_WORDS];
   logic [KPW-1:0]    key_ptr_q, word_ptr_q;
   logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q;

   logic           full, accept, push, pop;
   logic           key_wr, key_restart, key_last;
   logic [KPW-1:0] key_idx;

   assign full      = (count_q == FullCnt);
   assign accept    = in_valid & rdy;
   assign out_valid = (count_q != '0);
   assign pop       = out_valid & out_rcvd;
   assign data_out  = fifo_q[rd_ptr_q];

   // A restarted load always writes key[0], whatever key_ptr holds.
   assign key_idx  = key_restart ? '0 : key_ptr_q;
   assign key_last = (key_idx == KeyLast);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath strobes
   always_comb begin
      state_d     = state_q;
      key_wr      = 1'b0;
      key_restart = 1'b0;
      push        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (key_config) begin
                  key_wr      = 1'b1;
                  key_restart = 1'b1;
                  state_d     = key_last ? StReady : StLoad;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StLoad: begin
            if (accept) begin
               if (key_config) begin
                  key_wr = 1'b1;
                  if (key_last) state_d = StReady;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StReady: begin
            if (accept) begin
               if (!key_config) begin
                  push = 1'b1;
               end else if (ReloadEn) begin
                  key_wr      = 1'b1;
                  key_restart = 1'b1;
                  state_d     = key_last ? StReady : StLoad;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StErr:   ;
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      rdy        = 1'b0;
      error      = 1'b0;
      key_loaded = 1'b0;
      unique case (state_q)
         StIdle, StLoad: rdy = live_q;
         StReady: begin
            rdy        = ~full;
            key_loaded = 1'b1;
         end
         StErr:   error = 1'b1;
         default: ;
      endcase
   end

   // Key store, pointers and FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // live_q holds rdy low until the first edge after reset release.
         live_q     <= 1'b0;
         key_ptr_q  <= '0;
         word_ptr_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         live_q <= 1'b1;
         if (key_wr) begin
            key_q[key_idx] <= data_in;
            key_ptr_q      <= key_last ? '0 : key_idx + 1'b1;
         end
         if (key_wr && key_last) begin
            word_ptr_q <= '0;
         end else if (push) begin
            word_ptr_q <= (word_ptr_q == KeyLast) ? '0 : word_ptr_q + 1'b1;
         end
         if (push) begin
            fifo_q[wr_ptr_q] <= data_in ^ key_q[word_ptr_q];
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dsec_stream_ctrl.sv
// tb_dsec_stream_ctrl: directed and randomized stimulus for dsec_stream_ctrl (default
// parameters), checked against a queue-based reference model of the controller.
module tb_dsec_stream_ctrl;

   localparam int KW = 3;
   localparam int DEPTH = 4;
   localparam logic [63:0] K0 = 64'h9474B8E8C73BCA7D;
   localparam logic [63:0] K1 = 64'h0123456789ABCDEF;
   localparam logic [63:0] K2 = 64'hFFFFFFFF00000000;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] data_in;
   logic        key_config, in_valid, out_rcvd;
   logic        rdy, out_valid, error, key_loaded;
   logic [63:0] data_out;

   int n_checks = 0;
   int n_err = 0;

   // Reference model
   logic [63:0] m_key [KW];
   logic [63:0] m_q [$];
   int          m_got, m_widx;
   bit          m_loaded, m_err, m_live;

   dsec_stream_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .key_config (key_config),
      .in_valid   (in_valid),
      .out_rcvd   (out_rcvd),
      .rdy        (rdy),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .error      (error),
      .key_loaded (key_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_rdy();
      return m_live && !m_err && (!m_loaded || m_q.size() < DEPTH);
   endfunction

   task automatic check_all();
      chk("rdy", {63'd0, rdy}, {63'd0, m_rdy()});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_q.size() > 0});
      if (m_q.size() > 0) chk("data_out", data_out, m_q[0]);
      chk("error", {63'd0, error}, {63'd0, m_err});
      chk("key_loaded", {63'd0, key_loaded}, {63'd0, m_loaded});
   endtask

   // Asynchronous reset applied away from the clock edge; outputs must clear at once.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      m_q.delete();
      for (int i = 0; i < KW; i++) m_key[i] = '0;
      m_got = 0; m_widx = 0; m_loaded = 0; m_err = 0; m_live = 0;
      chk("rst_rdy", {63'd0, rdy}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_error", {63'd0, error}, 64'd0);
      chk("rst_key_loaded", {63'd0, key_loaded}, 64'd0);
      chk("rst_data_out", data_out, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0; key_config = 1'b0; out_rcvd = 1'b0; data_in = '0;
      #1;
      chk("rst_rel_rdy", {63'd0, rdy}, 64'd0);
   endtask

   // One clock: drive inputs, advance the model with the accept/pop decided before the edge.
   task automatic cyc(input bit iv, input bit kc, input logic [63:0] d, input bit rc);
      bit acc, pp;
      in_valid = iv; key_config = kc; data_in = d; out_rcvd = rc;
      acc = iv && m_rdy();
      pp = rc && (m_q.size() > 0);
      @(posedge clk);
      #1;
      if (pp) void'(m_q.pop_front());
      if (acc) begin
         if (kc) begin
            if (m_loaded) begin
`ifdef DSEC_KEY_RELOAD_EN
               m_key[0] = d; m_got = 1; m_loaded = 0;
`else
               m_err = 1; m_loaded = 0;
`endif
            end else begin
               m_key[m_got] = d;
               m_got++;
               if (m_got == KW) begin
                  m_loaded = 1; m_widx = 0; m_got = 0;
               end
            end
         end else if (m_loaded) begin
            m_q.push_back(d ^ m_key[m_widx]);
            m_widx = (m_widx + 1) % KW;
         end else begin
            m_err = 1; m_loaded = 0;
         end
      end
      m_live = 1;
      check_all();
   endtask

   task automatic load_key(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
      cyc(1, 1, a, 0);
      cyc(1, 1, b, 0);
      cyc(1, 1, c, 0);
   endtask

   initial begin
      bit iv, kc, rc;
      logic [63:0] d;
      rst = 1'b0; in_valid = 1'b0; key_config = 1'b0; out_rcvd = 1'b0; data_in = '0;
      #3;

      // Reset, then key load and whitening with backpressure
      do_reset();
      cyc(0, 0, 0, 0);
      chk("rdy_after_release", {63'd0, rdy}, 64'd1);
      load_key(K0, K1, K2);
      chk("key_loaded", {63'd0, key_loaded}, 64'd1);
      repeat (4) cyc(1, 0, 64'd0, 0);
      chk("bp_full_rdy", {63'd0, rdy}, 64'd0);
      chk("white0", data_out, K0);
      cyc(1, 0, 64'hDEAD_BEEF_0000_0001, 0);
      chk("bp_ignored_rdy", {63'd0, rdy}, 64'd0);
      cyc(0, 0, 0, 1);
      chk("bp_pulse_rdy", {63'd0, rdy}, 64'd1);
      chk("white1", data_out, K1);
      cyc(1, 0, 64'h5555_5555_5555_5555, 1);
      chk("white2", data_out, K2);
      cyc(1, 0, 64'hAAAA_0000_FFFF_1234, 0);
      chk("refill_rdy", {63'd0, rdy}, 64'd0);
      cyc(0, 0, 0, 1);
      chk("white3_wrap", data_out, K0);
      repeat (5) cyc(0, 0, 0, 1);

      // Reset mid-stream with two words queued
      do_reset();
      cyc(0, 0, 0, 0);
      load_key(K0, K1, K2);
      cyc(1, 0, 64'h1111, 0);
      cyc(1, 0, 64'h2222, 0);
      do_reset();
      cyc(0, 0, 0, 0);

      // Data word before any key
      cyc(1, 0, 64'h1234, 0);
      chk("err_nokey", {63'd0, error}, 64'd1);
      repeat (4) cyc(1, 1, {$urandom, $urandom}, 1);
      chk("err_sticky", {63'd0, error}, 64'd1);

      // key_config falls after one of three key words
      do_reset();
      cyc(0, 0, 0, 0);
      cyc(1, 1, K1, 0);
      cyc(1, 0, 64'h77, 0);
      chk("err_short_key", {63'd0, error}, 64'd1);
      repeat (3) cyc(0, 0, 0, 1);

      // Reload while two words are queued
      do_reset();
      cyc(0, 0, 0, 0);
      load_key(K0, K1, K2);
      cyc(1, 0, 64'hF0F0, 0);
      cyc(1, 0, 64'h0F0F, 0);
      load_key(64'h1, 64'h2, 64'h3);
`ifdef DSEC_KEY_RELOAD_EN
      chk("reload_no_err", {63'd0, error}, 64'd0);
`else
      chk("reload_err", {63'd0, error}, 64'd1);
`endif
      cyc(1, 0, 64'h100, 0);
      cyc(1, 0, 64'h200, 0);
      repeat (5) cyc(0, 0, 0, 1);

      // Randomized traffic with occasional protocol violations and resets
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 80) == 0) begin
            do_reset();
         end else begin
            iv = ($urandom_range(0, 3) != 0);
            kc = m_loaded ? ($urandom_range(0, 25) == 0) : ($urandom_range(0, 25) != 0);
            d  = {$urandom, $urandom};
            rc = ($urandom_range(0, 2) != 0);
            cyc(iv, kc, d, rc);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
